vdd_fault_monitor: RTL
======================

Name: vdd_fault_monitor

Overview:
Upstream neighbour of the power supply sequencer. Qualifies raw VDD ADC samples against under/over-voltage thresholds with hysteresis and consecutive-sample debounce, then drives the registered vdd_fault level that the sequencer consumes for safe-state entry and recovery. Also latches fault cause and counts fault episodes for diagnostics.

Parameters:
- ADC_W, 12, ADC sample width.
- CNT_W, 8, width of debounce thresholds, debounce counter and fault_count.
- ADC_TIMEOUT, 1024, cycles without adc_valid before a stale-sample fault (used only with VDD_ADC_WATCHDOG_EN).

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- adc_sample  in  ADC_W  VDD sample, unsigned; meaningful only when adc_valid=1.
- adc_valid  in  1  one-cycle strobe; qualifies adc_sample.
- uv_thresh  in  ADC_W  under-voltage limit; live, not captured.
- ov_thresh  in  ADC_W  over-voltage limit; live.
- hyst  in  ADC_W  recovery hysteresis; live.
- deb_assert  in  CNT_W  consecutive bad samples needed to declare a fault; 0 is treated as 1.
- deb_release  in  CNT_W  consecutive in-band samples needed to clear a fault; 0 is treated as 1.
- vdd_fault  out  1  registered fault level to the sequencer.
- uv_flag  out  1  fault cause: under-voltage.
- ov_flag  out  1  fault cause: over-voltage.
- stale_flag  out  1  fault cause: ADC watchdog; tied 0 when the feature is compiled out.
- fault_count  out  CNT_W  saturating count of FAULT entries.
- mon_state  out  2  FSM state, for debug.

Behaviour:
- Reset (synchronous, active-high): state=NORMAL, debounce counter=0, and all outputs 0. Reset mid-debounce or mid-fault discards everything and drops vdd_fault on the next edge.
- Only cycles with adc_valid=1 advance the debounce logic. Cycles with adc_valid=0 hold state and counter.
- bad = (sample < uv_thresh) | (sample > ov_thresh).
- in_band = (sample >= uv_thresh + hyst) & (sample <= ov_thresh - hyst).
  - Compute with ADC_W+1-bit arithmetic.
  - ov_thresh - hyst saturates at 0.
  - uv_thresh + hyst > max code means in_band is never true.
- States: NORMAL=0, PENDING=1, FAULT=2, RECOVER=3.
- NORMAL:
  - valid & bad: cnt=1. Go to FAULT if effective deb_assert==1, else PENDING.
- PENDING:
  - valid & !bad: go to NORMAL, cnt=0.
  - valid & bad: cnt+1. Go to FAULT when cnt+1 >= deb_assert.
- FAULT entry:
  - uv_flag = under-voltage of the triggering sample; ov_flag = over-voltage of the triggering sample. Both are set if thresholds are misconfigured (uv > ov).
  - fault_count increments, saturating at all-ones.
  - cnt=0.
- FAULT:
  - valid & in_band: cnt=1. Go to NORMAL if effective deb_release==1, else RECOVER.
  - Samples between the fault threshold and the hysteresis band hold FAULT.
- RECOVER:
  - valid & in_band: cnt+1. Go to NORMAL when cnt+1 >= deb_release.
  - valid & !in_band: go back to FAULT, cnt=0. This is not a new entry: fault_count and flags are unchanged.
- NORMAL entry: uv_flag, ov_flag and stale_flag clear.
- vdd_fault = 1 in FAULT and RECOVER.
- Latency: vdd_fault rises on the clock edge that consumes the deb_assert-th consecutive bad valid sample, i.e. it is visible in the following cycle. It falls likewise on the deb_release-th in-band sample.
- Live threshold changes take effect on the next valid sample. The counter is not reset by them.
- Counter saturates at all-ones and never wraps.

Optional Feature:
- Macro: VDD_ADC_WATCHDOG_EN.
- Defined:
  - An idle counter increments every cycle without adc_valid and resets to 0 on adc_valid.
  - On reaching ADC_TIMEOUT (from any state except FAULT): go to FAULT, set stale_flag, increment fault_count.
  - Recovery proceeds via the normal in-band rule.
  - If adc_valid and the timeout coincide, adc_valid wins: no timeout.
- Not defined: no idle counter, stale_flag constant 0, and the monitor holds state indefinitely while samples are absent.

Decomposition:
- Package vdd_mon_pkg: state encodings (NORMAL/PENDING/FAULT/RECOVER), ADC_W/CNT_W defaults, and a shared constant for the power_monitor fault-cause bit positions.
- One natural sub-module, vdd_band_compare: purely combinational; computes bad, in_band, under and over from the sample, thresholds and hyst, including the saturation rules. The FSM, counters and watchdog stay in the top module.

Test Plan:
Common setup: uv=0x800, ov=0xE00, hyst=0x020, deb_assert=4, deb_release=8.
1. Four consecutive valid 0x7F0 samples, spaced by idle cycles → vdd_fault=1 in the cycle after the 4th; uv_flag=1, ov_flag=0, fault_count=1.
2. Three 0x7F0 samples, then 0xA00, then three 0x7F0 → vdd_fault stays 0 and mon_state returns to PENDING; a 4th bad sample then asserts the fault.
3. From FAULT, seven samples at 0x810 (inside hysteresis) → stays FAULT. Then eight at 0xA00 → vdd_fault=0 after the 8th and uv_flag clears.
4. RECOVER after 5 in-band samples, then one 0xE10 → back to FAULT with fault_count unchanged, vdd_fault held at 1 throughout.
5. reset=1 for one cycle while in RECOVER → next cycle all outputs 0 and mon_state=NORMAL. deb_assert=0 with a single 0xF00 sample → immediate FAULT with ov_flag=1.
6. With VDD_ADC_WATCHDOG_EN and ADC_TIMEOUT=16: no adc_valid for 16 cycles → vdd_fault=1 and stale_flag=1. Eight 0xA00 samples then clear it. A valid sample on cycle 16 → no fault.

Source files
------------

// File: rtl/vdd_mon_pkg.sv
// vdd_mon_pkg: shared types and constants for the VDD fault monitor.
//   - state_e: monitor FSM encodings (also exported on mon_state for debug)
//   - ADC_W_DEF / CNT_W_DEF: default sample and counter widths
//   - CAUSE_*_BIT: fault-cause bit positions shared with power_monitor
package vdd_mon_pkg;

  localparam int unsigned ADC_W_DEF = 12;
  localparam int unsigned CNT_W_DEF = 8;

  // Fault-cause vector layout, common to the power_monitor family.
  localparam int unsigned CAUSE_UV_BIT    = 0;
  localparam int unsigned CAUSE_OV_BIT    = 1;
  localparam int unsigned CAUSE_STALE_BIT = 2;
  localparam int unsigned CAUSE_W         = 3;

  typedef enum logic [1:0] {
    ST_NORMAL  = 2'd0,
    ST_PENDING = 2'd1,
    ST_FAULT   = 2'd2,
    ST_RECOVER = 2'd3
  } state_e;

endpackage : vdd_mon_pkg

// File: rtl/vdd_band_compare.sv
// vdd_band_compare: combinational window compare of one VDD sample.
// Ports:
//   sample_i, uv_thresh_i, ov_thresh_i, hyst_i : sample and live limits
//   under_c / over_c : sample below uv / above ov
//   bad_c            : under_c | over_c
//   in_band_c        : sample inside [uv+hyst, ov-hyst]; ov-hyst saturates
//                      at 0 and an overflowing uv+hyst empties the band.
module vdd_band_compare #(
  parameter int unsigned ADC_W = 12
) (
  input  logic [ADC_W-1:0] sample_i,
  input  logic [ADC_W-1:0] uv_thresh_i,
  input  logic [ADC_W-1:0] ov_thresh_i,
  input  logic [ADC_W-1:0] hyst_i,
  output logic             under_c,
  output logic             over_c,
  output logic             bad_c,
  output logic             in_band_c
);

  localparam int unsigned EXT_W = ADC_W + 1;

  logic [EXT_W-1:0] band_lo;
  logic [ADC_W-1:0] band_hi;

  // Lower edge keeps the carry so an overflowing sum can never be met.
  assign band_lo = {1'b0, uv_thresh_i} + {1'b0, hyst_i};
  assign band_hi = (ov_thresh_i >= hyst_i) ? (ov_thresh_i - hyst_i) : '0;

  assign under_c   = (sample_i < uv_thresh_i);
  assign over_c    = (sample_i > ov_thresh_i);
  assign bad_c     = under_c | over_c;
  assign in_band_c = ({1'b0, sample_i} >= band_lo) && (sample_i <= band_hi);

endmodule : vdd_band_compare

// File: rtl/vdd_fault_monitor.sv
// vdd_fault_monitor: debounced under/over-voltage qualifier feeding the
// power supply sequencer.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   adc_sample, adc_valid : VDD sample and its one-cycle strobe
//   uv_thresh, ov_thresh, hyst : live window limits and recovery hysteresis
//   deb_assert, deb_release    : consecutive-sample debounce (0 acts as 1)
//   vdd_fault             : registered fault level (FAULT or RECOVER)
//   uv_flag, ov_flag, stale_flag : latched fault cause
//   fault_count           : saturating count of FAULT entries
//   mon_state             : FSM state for debug
// Optional: define VDD_ADC_WATCHDOG_EN to add the ADC_TIMEOUT idle watchdog.
module vdd_fault_monitor
  import vdd_mon_pkg::*;
#(
  parameter int unsigned ADC_W = ADC_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
`ifdef VDD_ADC_WATCHDOG_EN
  ,
  parameter int unsigned ADC_TIMEOUT = 1024
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [ADC_W-1:0] adc_sample,
  input  logic             adc_valid,
  input  logic [ADC_W-1:0] uv_thresh,
  input  logic [ADC_W-1:0] ov_thresh,
  input  logic [ADC_W-1:0] hyst,
  input  logic [CNT_W-1:0] deb_assert,
  input  logic [CNT_W-1:0] deb_release,
  output logic             vdd_fault,
  output logic             uv_flag,
  output logic             ov_flag,
  output logic             stale_flag,
  output logic [CNT_W-1:0] fault_count,
  output logic [1:0]       mon_state
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   fault_count_q, fault_count_d;
  logic [CAUSE_W-1:0] cause_q, cause_d;
  logic               vdd_fault_q, vdd_fault_d;

  logic               under_c, over_c, bad_c, in_band_c;
  logic [CNT_W-1:0]   eff_assert_c, eff_release_c, cnt_inc_c;
  logic               timeout_c;

  vdd_band_compare #(.ADC_W(ADC_W)) u_band (
    .sample_i    (adc_sample),
    .uv_thresh_i (uv_thresh),
    .ov_thresh_i (ov_thresh),
    .hyst_i      (hyst),
    .under_c     (under_c),
    .over_c      (over_c),
    .bad_c       (bad_c),
    .in_band_c   (in_band_c)
  );

  assign eff_assert_c  = (deb_assert  == '0) ? CNT_ONE : deb_assert;
  assign eff_release_c = (deb_release == '0) ? CNT_ONE : deb_release;
  assign cnt_inc_c     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

`ifdef VDD_ADC_WATCHDOG_EN
  localparam int unsigned IDLE_W = $clog2(ADC_TIMEOUT + 1);

  logic [IDLE_W-1:0] idle_q, idle_d;

  // Idle counter saturates at the timeout; any valid sample restarts it.
  always_comb begin
    idle_d = idle_q;
    if (adc_valid) begin
      idle_d = '0;
    end else if (idle_q != IDLE_W'(ADC_TIMEOUT)) begin
      idle_d = idle_q + IDLE_W'(1);
    end
  end

  // Fires on the edge that consumes the ADC_TIMEOUT-th idle cycle.
  assign timeout_c = !adc_valid && (idle_q >= IDLE_W'(ADC_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) idle_q <= '0;
    else       idle_q <= idle_d;
  end
`else
  assign timeout_c = 1'b0;
`endif

  // Next-state, debounce counter, cause and episode count.
  always_comb begin
    logic fault_entry;
    fault_entry   = 1'b0;
    state_d       = state_q;
    cnt_d         = cnt_q;
    cause_d       = cause_q;
    fault_count_d = fault_count_q;

    if (adc_valid) begin
      unique case (state_q)
        ST_NORMAL: begin
          if (bad_c) begin
            cnt_d = CNT_ONE;
            if (eff_assert_c == CNT_ONE) fault_entry = 1'b1;
            else                         state_d     = ST_PENDING;
          end
        end
        ST_PENDING: begin
          if (!bad_c) begin
            state_d = ST_NORMAL;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc_c;
            if (cnt_inc_c >= eff_assert_c) fault_entry = 1'b1;
          end
        end
        ST_FAULT: begin
          if (in_band_c) begin
            if (eff_release_c == CNT_ONE) begin
              state_d = ST_NORMAL;
              cnt_d   = '0;
              cause_d = '0;
            end else begin
              state_d = ST_RECOVER;
              cnt_d   = CNT_ONE;
            end
          end
        end
        ST_RECOVER: begin
          if (in_band_c) begin
            if (cnt_inc_c >= eff_release_c) begin
              state_d = ST_NORMAL;
              cnt_d   = '0;
              cause_d = '0;
            end else begin
              cnt_d = cnt_inc_c;
            end
          end else begin
            // Fall-back is the same episode: cause and count untouched.
            state_d = ST_FAULT;
            cnt_d   = '0;
          end
        end
        default: state_d = ST_NORMAL;
      endcase

      if (fault_entry) begin
        state_d                  = ST_FAULT;
        cnt_d                    = '0;
        cause_d[CAUSE_UV_BIT]    = under_c;
        cause_d[CAUSE_OV_BIT]    = over_c;
        cause_d[CAUSE_STALE_BIT] = 1'b0;
      end
    end else if (timeout_c && (state_q != ST_FAULT)) begin
      fault_entry              = 1'b1;
      state_d                  = ST_FAULT;
      cnt_d                    = '0;
      cause_d[CAUSE_STALE_BIT] = 1'b1;
    end

    if (fault_entry && (fault_count_q != CNT_MAX)) begin
      fault_count_d = fault_count_q + CNT_ONE;
    end

    vdd_fault_d = (state_d == ST_FAULT) || (state_d == ST_RECOVER);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_NORMAL;
      cnt_q         <= '0;
      cause_q       <= '0;
      fault_count_q <= '0;
      vdd_fault_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cause_q       <= cause_d;
      fault_count_q <= fault_count_d;
      vdd_fault_q   <= vdd_fault_d;
    end
  end

  assign vdd_fault   = vdd_fault_q;
  assign uv_flag     = cause_q[CAUSE_UV_BIT];
  assign ov_flag     = cause_q[CAUSE_OV_BIT];
  assign stale_flag  = cause_q[CAUSE_STALE_BIT];
  assign fault_count = fault_count_q;
  assign mon_state   = state_q;

endmodule : vdd_fault_monitor
